// File: rtl/mips_pkg.sv
// Shared fetch/branch constants and the PC increment helper.
package mips_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned IMEM_DEPTH = 128;
    localparam logic [ADDR_W-1:0] IMEM_RESET_PC = '0;

    function automatic logic [ADDR_W-1:0] pc_inc(
        input logic [ADDR_W-1:0] pc,
        input int unsigned depth = IMEM_DEPTH
    );
        return (pc == ADDR_W'(depth - 1)) ? '0 : pc + ADDR_W'(1);
    endfunction

endpackage

// File: rtl/fetch_pc_sel.sv
// Next-PC and memory address select: redirect beats stall beats increment.
module fetch_pc_sel
    import mips_pkg::*;
#(
    parameter int unsigned MEM_DEPTH = IMEM_DEPTH,
    parameter int AW = $clog2(MEM_DEPTH)
) (
    input  logic          stall,
    input  logic          redirect_valid,
    input  logic [AW-1:0] redirect_pc,
    input  logic [AW-1:0] pc_q,
    input  logic [AW-1:0] infl_pc_q,
    input  logic          infl_valid_q,
    output logic [AW-1:0] addr_o,
    output logic [AW-1:0] pc_d,
    output logic [AW-1:0] infl_pc_d,
    output logic          infl_valid_d,
    output logic          accept_o
);

    logic [AW-1:0] pc_nxt;

    assign pc_nxt = AW'(pc_inc(ADDR_W'(pc_q), MEM_DEPTH));
    assign accept_o = infl_valid_q & ~stall & ~redirect_valid;

    always_comb begin
        addr_o = pc_q;
        pc_d = pc_q;
        infl_pc_d = infl_pc_q;
        infl_valid_d = infl_valid_q;
        case (1'b1)
            redirect_valid: begin
                pc_d = redirect_pc;
                infl_valid_d = 1'b0;
            end
            // re-issue the held word so mem_data repeats it next cycle
            stall: addr_o = infl_pc_q;
            default: begin
                pc_d = pc_nxt;
                infl_pc_d = pc_q;
                infl_valid_d = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC registers, in-flight tag and delivered-instruction counter.
module fetch_unit
    import mips_pkg::*;
#(
    parameter int unsigned MEM_DEPTH = IMEM_DEPTH,
    parameter logic [ADDR_W-1:0] RESET_PC = IMEM_RESET_PC,
    parameter int AW = $clog2(MEM_DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic [INSTR_W-1:0] mem_data,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic [ADDR_W-1:0]  instr_npc,
    output logic               instr_valid,
    output logic [31:0]        fetch_count
);

    localparam logic [AW-1:0] RST_PC = RESET_PC[AW-1:0];

    logic [AW-1:0] pc_q, pc_d;
    logic [AW-1:0] infl_pc_q, infl_pc_d;
    logic          infl_valid_q, infl_valid_d;
    logic [31:0]   fetch_count_q;
    logic [AW-1:0] addr;
    logic          accept;
    logic          unused_rpc;

    assign unused_rpc = ^redirect_pc[ADDR_W-1:AW];

    fetch_pc_sel #(
        .MEM_DEPTH(MEM_DEPTH),
        .AW(AW)
    ) u_sel (
        .stall(stall),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc[AW-1:0]),
        .pc_q(pc_q),
        .infl_pc_q(infl_pc_q),
        .infl_valid_q(infl_valid_q),
        .addr_o(addr),
        .pc_d(pc_d),
        .infl_pc_d(infl_pc_d),
        .infl_valid_d(infl_valid_d),
        .accept_o(accept)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RST_PC;
            infl_pc_q <= RST_PC;
            infl_valid_q <= 1'b0;
            fetch_count_q <= '0;
        end else begin
            pc_q <= pc_d;
            infl_pc_q <= infl_pc_d;
            infl_valid_q <= infl_valid_d;
            if (accept) fetch_count_q <= fetch_count_q + 32'd1;
        end
    end

    assign mem_addr = rst ? ADDR_W'(RST_PC) : ADDR_W'(addr);
    assign instr = mem_data;
    assign instr_pc = ADDR_W'(infl_pc_q);
    assign instr_npc = pc_inc(ADDR_W'(infl_pc_q), MEM_DEPTH);
    assign instr_valid = infl_valid_q & ~rst;
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed-vector bench for fetch_unit with a 1-cycle synchronous instruction memory.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] instr_npc;
    logic        instr_valid;
    logic [31:0] fetch_count;

    logic [31:0] mem [128];

    int n_checks = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    always_ff @(posedge clk) mem_data <= mem[mem_addr[6:0]];

    fetch_unit dut (
        .clk(clk),
        .rst(rst),
        .stall(stall),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .mem_addr(mem_addr),
        .mem_data(mem_data),
        .instr(instr),
        .instr_pc(instr_pc),
        .instr_npc(instr_npc),
        .instr_valid(instr_valid),
        .fetch_count(fetch_count)
    );

    typedef struct {
        logic        rst;
        logic        stall;
        logic        rv;
        logic [31:0] rpc;
        logic        e_valid;
        logic        chk_i;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
        logic [31:0] e_npc;
        logic [31:0] e_addr;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t vecs [30];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic s, input logic v,
                         input logic [31:0] p);
        rst = r;
        stall = s;
        redirect_valid = v;
        redirect_pc = p;
        #1;
    endtask

    function automatic vec_t mk(input logic r, input logic s, input logic v,
                                input logic [31:0] p, input logic ev,
                                input logic ci, input logic [31:0] ei,
                                input logic [31:0] ep, input logic [31:0] en,
                                input logic [31:0] ea, input logic [31:0] ec);
        vec_t t;
        t.rst = r; t.stall = s; t.rv = v; t.rpc = p;
        t.e_valid = ev; t.chk_i = ci; t.e_instr = ei;
        t.e_pc = ep; t.e_npc = en; t.e_addr = ea; t.e_cnt = ec;
        return t;
    endfunction

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 32'hDEAD0000 | i;
        mem[0] = 32'hA00000AA;
        for (int n = 1; n < 10; n++)
            mem[n] = (32'(n) << 28) | (32'(n) << 4) | 32'(n);
        mem[127] = 32'hF000007F;

        //          rst stl rv rpc     val chk instr         pc   npc  addr cnt
        vecs[0]  = mk(1, 0, 0, 0,      0, 0, 0,            0,   0,   0,   0);
        vecs[1]  = mk(0, 0, 0, 0,      0, 0, 0,            0,   0,   0,   0);
        vecs[2]  = mk(0, 0, 0, 0,      1, 1, 32'hA00000AA, 0,   1,   1,   0);
        vecs[3]  = mk(0, 0, 0, 0,      1, 1, 32'h10000011, 1,   2,   2,   1);
        vecs[4]  = mk(0, 1, 0, 0,      1, 1, 32'h20000022, 2,   3,   2,   2);
        vecs[5]  = mk(0, 1, 0, 0,      1, 1, 32'h20000022, 2,   3,   2,   2);
        vecs[6]  = mk(0, 1, 0, 0,      1, 1, 32'h20000022, 2,   3,   2,   2);
        vecs[7]  = mk(0, 0, 0, 0,      1, 1, 32'h20000022, 2,   3,   3,   2);
        vecs[8]  = mk(0, 0, 0, 0,      1, 1, 32'h30000033, 3,   4,   4,   3);
        vecs[9]  = mk(0, 0, 0, 0,      1, 1, 32'h40000044, 4,   5,   5,   4);
        vecs[10] = mk(0, 0, 1, 7,      1, 1, 32'h50000055, 5,   6,   6,   5);
        vecs[11] = mk(0, 0, 0, 0,      0, 0, 0,            0,   0,   7,   5);
        vecs[12] = mk(0, 0, 0, 0,      1, 1, 32'h70000077, 7,   8,   8,   5);
        vecs[13] = mk(0, 1, 1, 9,      1, 1, 32'h80000088, 8,   9,   9,   6);
        vecs[14] = mk(0, 0, 0, 0,      0, 0, 0,            0,   0,   9,   6);
        vecs[15] = mk(0, 0, 0, 0,      1, 1, 32'h90000099, 9,   10,  10,  6);
        vecs[16] = mk(0, 0, 1, 127,    1, 1, 32'hDEAD000A, 10,  11,  11,  7);
        vecs[17] = mk(0, 0, 0, 0,      0, 0, 0,            0,   0,   127, 7);
        vecs[18] = mk(0, 0, 0, 0,      1, 1, 32'hF000007F, 127, 0,   0,   7);
        vecs[19] = mk(0, 0, 1, 32'h185, 1, 1, 32'hA00000AA, 0,  1,   1,   8);
        vecs[20] = mk(0, 0, 0, 0,      0, 0, 0,            0,   0,   5,   8);
        vecs[21] = mk(0, 0, 0, 0,      1, 1, 32'h50000055, 5,   6,   6,   8);
        vecs[22] = mk(0, 1, 0, 0,      1, 1, 32'h60000066, 6,   7,   6,   9);
        vecs[23] = mk(1, 1, 0, 0,      0, 0, 0,            0,   0,   0,   9);
        vecs[24] = mk(0, 0, 0, 0,      0, 0, 0,            0,   0,   0,   0);
        vecs[25] = mk(0, 0, 0, 0,      1, 1, 32'hA00000AA, 0,   1,   1,   0);
        vecs[26] = mk(0, 0, 1, 3,      1, 1, 32'h10000011, 1,   2,   2,   1);
        vecs[27] = mk(1, 0, 1, 4,      0, 0, 0,            0,   0,   0,   1);
        vecs[28] = mk(0, 0, 0, 0,      0, 0, 0,            0,   0,   0,   0);
        vecs[29] = mk(0, 0, 0, 0,      1, 1, 32'hA00000AA, 0,   1,   1,   0);

        drive(1, 0, 0, 0);
        tick();
        tick();

        for (int i = 0; i < 30; i++) begin
            tick();
            drive(vecs[i].rst, vecs[i].stall, vecs[i].rv, vecs[i].rpc);
            chk($sformatf("v%0d valid", i), 32'(instr_valid),
                32'(vecs[i].e_valid));
            chk($sformatf("v%0d addr", i), mem_addr, vecs[i].e_addr);
            chk($sformatf("v%0d count", i), fetch_count, vecs[i].e_cnt);
            if (vecs[i].chk_i) begin
                chk($sformatf("v%0d instr", i), instr, vecs[i].e_instr);
                chk($sformatf("v%0d pc", i), instr_pc, vecs[i].e_pc);
                chk($sformatf("v%0d npc", i), instr_npc, vecs[i].e_npc);
            end
        end

        // back-to-back redirects: only the last target is fetched
        tick();
        drive(0, 0, 1, 2);
        tick();
        drive(0, 0, 1, 4);
        chk("b2b valid1", 32'(instr_valid), 32'd0);
        tick();
        drive(0, 1, 1, 6);
        chk("b2b addr2", mem_addr, 32'd4);
        tick();
        drive(0, 0, 0, 0);
        chk("b2b valid3", 32'(instr_valid), 32'd0);
        chk("b2b addr3", mem_addr, 32'd6);
        tick();
        drive(0, 0, 0, 0);
        chk("b2b valid4", 32'(instr_valid), 32'd1);
        chk("b2b instr4", instr, 32'h60000066);
        chk("b2b pc4", instr_pc, 32'd6);
        chk("b2b count4", fetch_count, 32'd1);
        tick();
        drive(0, 0, 0, 0);
        chk("b2b instr5", instr, 32'h70000077);
        chk("b2b count5", fetch_count, 32'd2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch initiator that drives the word-indexed, 1-cycle synchronous-read instruction memory of the fetch stage and consumes its data. It holds the PC, issues one read per cycle, tags returned words with their PC and next PC, and presents them to decode with a valid flag. It supports decode-side stall (back-pressure) and branch/jump redirect. It also counts delivered instructions.

Parameters:
MEM_DEPTH, 128, number of 32-bit words in instruction memory; PC wraps modulo MEM_DEPTH
RESET_PC, 0, word address fetched first after reset
AW, $clog2(MEM_DEPTH), significant PC bits; upper bits of every PC output are zero

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  synchronous, active-high reset
stall  input  1  decode not accepting; hold the current instruction output
redirect_valid  input  1  redirect fetch to redirect_pc; overrides stall
redirect_pc  input  32  redirect target word address; only low AW bits used
mem_addr  output  32  word address to instruction memory (read data appears next cycle)
mem_data  input  32  registered read data from instruction memory
instr  output  32  fetched instruction; equals mem_data
instr_pc  output  32  word address of instr
instr_npc  output  32  (instr_pc+1) mod MEM_DEPTH
instr_valid  output  1  instr/instr_pc/instr_npc are meaningful
fetch_count  output  32  number of instructions accepted by decode since reset

Behaviour:
- State: pc_q (AW bits, next address to issue); infl_pc (AW bits, address issued last cycle); infl_valid (1 bit); fetch_count.
- Reset (rst=1 at an edge): pc_q<=RESET_PC, infl_pc<=RESET_PC, infl_valid<=0, fetch_count<=0. While rst=1: mem_addr=RESET_PC and instr_valid=0 (forced combinationally). Reset mid-stall or mid-redirect clears everything; no partial state survives.
- Outputs: instr=mem_data; instr_pc=infl_pc; instr_npc=(infl_pc+1) mod MEM_DEPTH; instr_valid=infl_valid.
- mem_addr (combinational): redirect_valid ? pc_q : (stall ? infl_pc : pc_q). During a stall it re-issues infl_pc, so mem_data next cycle repeats the held instruction. No hold buffer is needed.
- Normal (no stall, no redirect): infl_pc<=pc_q; infl_valid<=1; pc_q<=(pc_q+1) mod MEM_DEPTH. Throughput is 1 instr/cycle. Latency from address issue to instr_valid is 1 cycle.
- Stall (stall=1, redirect_valid=0): pc_q, infl_pc and infl_valid hold. Outputs stay stable for the whole stall. fetch_count holds.
- Redirect (redirect_valid=1, any stall): pc_q<=redirect_pc[AW-1:0]; infl_valid<=0. The output presented in the redirect cycle is killed and not counted.
  - Next cycle: instr_valid=0 and mem_addr=redirect target.
  - The cycle after: target instruction valid. Penalty is 1 bubble.
- Acceptance: an output is accepted when instr_valid=1, stall=0, redirect_valid=0, rst=0. On acceptance fetch_count<=fetch_count+1, wrapping at 2^32.
- Wrap-around: pc_q = MEM_DEPTH-1 increments to 0. instr_npc of word MEM_DEPTH-1 is 0.
- First cycle after reset release: mem_addr=RESET_PC, instr_valid=0. One cycle later: instr=MEM[RESET_PC], instr_valid=1.
- Back-to-back redirects: each restarts fetch. Only the last target is fetched.

Decomposition:
- Shared package (mips_pkg):
  - INSTR_W=32, ADDR_W=32, IMEM_DEPTH=128 and RESET_PC constants.
  - Function pc_inc(pc) returning (pc+1) mod IMEM_DEPTH; this function is shared with the branch-target logic.
- One natural sub-module, fetch_pc_sel: the combinational next-pc / mem_addr select (redirect > stall > increment).
- Top-level holds the registers and counter.

Test Plan:
- Bench preloads memory with MEM[0..9] = 0xA00000AA, 0x10000011, 0x20000022 … 0x90000099 (MEM[n] = 0xn00000nn for n=1..9).
- Reset then free-run 5 cycles -> instr_valid rises 1 cycle after rst falls; instr = 0xA00000AA, 0x10000011, 0x20000022, 0x30000033 with instr_pc 0,1,2,3 and instr_npc 1,2,3,4; fetch_count=4.
- Stall 3 cycles while instr=0x20000022 (pc 2) -> instr, instr_pc and instr_valid are stable all 3 cycles and mem_addr=2 during the stall; after release, next is 0x30000033; fetch_count is not incremented during the stall.
- redirect_valid with redirect_pc=7 while instr=0x10000011 -> next cycle instr_valid=0 and mem_addr=7; following cycle instr=0x70000077, instr_pc=7; the killed 0x10000011 is not counted.
- redirect_valid and stall both high, redirect_pc=9 -> redirect wins; instr=0x90000099 two cycles later.
- redirect_pc=127, free-run -> instr_pc 127 then 0; instr_npc of 127 is 0; redirect_pc=0x00000185 -> fetches word 5 (0x50000055).
- rst asserted for 1 cycle mid-stream (and mid-stall) -> instr_valid=0 during and one cycle after; restart at pc 0 with instr 0xA00000AA; fetch_count=0.
